// File: rtl/up_down_control_pkg.sv
// Shared types and defaults for the up/down direction controller.
// Imported by the debouncer, the interface users and the top level.
package up_down_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_WIDTH           = 4;

    // Wide enough for the largest legal debounce length (255).
    localparam int DEBOUNCE_CNT_W = 8;

    function automatic dir_state_t flip_dir(input dir_state_t dir);
        return (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
    endfunction

endpackage

// File: rtl/up_down_control_if.sv
// Button/mode/count inputs and direction outputs of the up/down controller.
interface up_down_control_if #(
    parameter int WIDTH = 4
);
    logic             button;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             upDown;
    logic             toggled;
    logic             btn_level;

    modport master (
        output button, mode, count,
        input  upDown, toggled, btn_level
    );

    modport slave (
        input  button, mode, count,
        output upDown, toggled, btn_level
    );
endinterface

// File: rtl/up_down_control_debounce.sv
// Two-flop synchronizer, consecutive-cycle debounce counter and press detector.
// press is high in the cycle whose closing edge raises level from 0 to 1.
module button_debounce
    import up_down_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic press
);

    localparam logic [DEBOUNCE_CNT_W-1:0] LAST_COUNT = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                      sync_meta;
    logic                      sync_q;
    logic                      level_q;
    logic [DEBOUNCE_CNT_W-1:0] stable_cnt;
    logic                      differs;
    logic                      accept;

    assign differs = (sync_q != level_q);
    assign accept  = differs && (stable_cnt == LAST_COUNT);

    // The counter clears on any cycle of agreement, so only an unbroken run is accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta  <= 1'b0;
            sync_q     <= 1'b0;
            level_q    <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_meta <= button;
            sync_q    <= sync_meta;
            if (!differs) begin
                stable_cnt <= '0;
            end else if (accept) begin
                stable_cnt <= '0;
                level_q    <= sync_q;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign press = accept && sync_q;

endmodule

// File: rtl/up_down_control.sv
// Direction controller for an external up/down counter: button toggles direction,
// ping-pong mode additionally reverses one step before each end of the count range.
module up_down_control
    import up_down_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int WIDTH           = DEFAULT_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    up_down_control_if.slave   ctrl
);

    localparam int               COUNT_MAX = 2**WIDTH - 1;
    localparam logic [WIDTH-1:0] TURN_HIGH = WIDTH'(COUNT_MAX - 1);
    localparam logic [WIDTH-1:0] TURN_LOW  = WIDTH'(1);

    dir_state_t state_q;
    dir_state_t state_d;
    logic       toggled_q;
    logic       flip;
    logic       at_turn;
    logic       level;
    logic       press;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .reset  (reset),
        .button (ctrl.button),
        .level  (level),
        .press  (press)
    );

    // Turning one step early lets the counter land on the end value, then reverse.
    always_comb begin
        state_d = state_q;
        at_turn = 1'b0;
        flip    = 1'b0;
        if (ctrl.mode) begin
            at_turn = (state_q == DIR_UP) ? (ctrl.count == TURN_HIGH)
                                          : (ctrl.count == TURN_LOW);
        end
        flip = press || at_turn;
        if (flip) begin
            state_d = flip_dir(state_q);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= DIR_UP;
            toggled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            toggled_q <= flip;
        end
    end

    assign ctrl.upDown    = (state_q == DIR_UP);
    assign ctrl.toggled   = toggled_q;
    assign ctrl.btn_level = level;

endmodule

// File: tb/tb_up_down_control.sv
// Directed bench for up_down_control closed around a 4-bit up/down counter,
// with a window-based reference model compared on every falling edge.
module tb_up_down_control;
    import up_down_pkg::*;

    localparam int DEB   = 4;
    localparam int WIDTH = 4;
    localparam int CMAX  = 2**WIDTH - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;

    up_down_control_if #(.WIDTH(WIDTH)) bus();

    up_down_control #(
        .DEBOUNCE_CYCLES(DEB),
        .WIDTH          (WIDTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ctrl  (bus)
    );

    always #5 clock = ~clock;

    int nCompared   = 0;
    int nMismatched = 0;
    int togSeen     = 0;

    // Downstream counter, with a load port so tests can preset the count
    logic [WIDTH-1:0] cntQ;
    logic             loadReq = 1'b0;
    logic [WIDTH-1:0] loadVal = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset)        cntQ <= '0;
        else if (loadReq)  cntQ <= loadVal;
        else if (bus.upDown) cntQ <= cntQ + 1'b1;
        else               cntQ <= cntQ - 1'b1;
    end

    assign bus.count = cntQ;

    // Reference: level accepts when the last DEB synchronized samples all disagree with it
    logic           mS1, mS2, mLevel, mDirUp, mTog;
    logic [DEB-1:0] mHist;
    logic [DEB-1:0] mWin;
    logic           mAllDiff, mTurn, mFlip;

    always_comb begin
        mWin     = {mHist[DEB-2:0], mS2};
        mAllDiff = (mWin == {DEB{~mLevel}});
        mTurn    = bus.mode && (mDirUp ? (cntQ == WIDTH'(CMAX - 1)) : (cntQ == WIDTH'(1)));
        mFlip    = (mAllDiff && !mLevel) || mTurn;
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mS1    <= 1'b0;
            mS2    <= 1'b0;
            mHist  <= '0;
            mLevel <= 1'b0;
            mDirUp <= 1'b1;
            mTog   <= 1'b0;
        end else begin
            mS1    <= bus.button;
            mS2    <= mS1;
            mHist  <= mWin;
            mLevel <= mAllDiff ? ~mLevel : mLevel;
            mDirUp <= mFlip ? ~mDirUp : mDirUp;
            mTog   <= mFlip;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        checkOutput("model_upDown",    32'(bus.upDown),    32'(mDirUp));
        checkOutput("model_toggled",   32'(bus.toggled),   32'(mTog));
        checkOutput("model_btn_level", 32'(bus.btn_level), 32'(mLevel));
        if (bus.toggled) togSeen++;
    end

    task automatic applyStimulus(input logic btn, input logic md, input int cycles);
        bus.button = btn;
        bus.mode   = md;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic doReset(input int cycles);
        #2 reset = 1'b0;
        repeat (cycles) @(negedge clock);
        reset = 1'b1;
    endtask

    int ppExp [32] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                       14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int togBefore;

    initial begin
        bus.button = 1'b1;
        bus.mode   = 1'b0;
        reset      = 1'b0;

        $display("[TB] reset hold with button pressed");
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("rst_upDown",    32'(bus.upDown),    32'(1));
            checkOutput("rst_toggled",   32'(bus.toggled),   32'(0));
            checkOutput("rst_btn_level", 32'(bus.btn_level), 32'(0));
        end
        reset = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clock);
            if (e == 5) checkOutput("lat_edge5_upDown", 32'(bus.upDown), 32'(1));
            if (e == 6) begin
                checkOutput("lat_edge6_upDown",  32'(bus.upDown),    32'(0));
                checkOutput("lat_edge6_level",   32'(bus.btn_level), 32'(1));
                checkOutput("lat_edge6_toggled", 32'(bus.toggled),   32'(1));
            end
            if (e == 7) checkOutput("lat_edge7_toggled", 32'(bus.toggled), 32'(0));
        end
        applyStimulus(1'b0, 1'b0, 10);

        $display("[TB] manual mode glitches and presses");
        doReset(2);
        for (int w = 1; w <= 3; w++) begin
            applyStimulus(1'b1, 1'b0, w);
            applyStimulus(1'b0, 1'b0, 8);
            checkOutput("glitch_upDown", 32'(bus.upDown),    32'(1));
            checkOutput("glitch_level",  32'(bus.btn_level), 32'(0));
        end
        togBefore = togSeen;
        applyStimulus(1'b1, 1'b0, 10);
        checkOutput("press1_upDown", 32'(bus.upDown), 32'(0));
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("press1_release_upDown", 32'(bus.upDown), 32'(0));
        checkOutput("press1_toggle_count", 32'(togSeen - togBefore), 32'(1));
        applyStimulus(1'b1, 1'b0, 10);
        checkOutput("press2_upDown", 32'(bus.upDown), 32'(1));
        applyStimulus(1'b0, 1'b0, 10);

        $display("[TB] ping-pong closed loop");
        bus.mode = 1'b1;
        doReset(2);
        for (int i = 0; i < 32; i++) begin
            checkOutput("pingpong_count", 32'(cntQ), 32'(ppExp[i]));
            if (i == 15 || i == 30) checkOutput("pingpong_toggled", 32'(bus.toggled), 32'(1));
            @(negedge clock);
        end

        $display("[TB] press coinciding with upper turn point");
        doReset(2);
        applyStimulus(1'b0, 1'b1, 9);
        togBefore = togSeen;
        applyStimulus(1'b1, 1'b1, 6);
        checkOutput("sim_count_top", 32'(cntQ),        32'(15));
        checkOutput("sim_upDown",    32'(bus.upDown),  32'(0));
        checkOutput("sim_toggled",   32'(bus.toggled), 32'(1));
        applyStimulus(1'b0, 1'b1, 6);
        checkOutput("sim_count_after", 32'(cntQ), 32'(9));
        checkOutput("sim_toggle_count", 32'(togSeen - togBefore), 32'(1));

        $display("[TB] entering ping-pong at the top of the range");
        bus.mode = 1'b0;
        doReset(2);
        loadVal = WIDTH'(15);
        loadReq = 1'b1;
        @(negedge clock);
        loadReq = 1'b0;
        checkOutput("late_load_count", 32'(cntQ), 32'(15));
        bus.mode = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clock);
            if (i == 1) begin
                checkOutput("late_wrap_count",  32'(cntQ),       32'(0));
                checkOutput("late_wrap_upDown", 32'(bus.upDown), 32'(1));
            end
            if (i == 16) begin
                checkOutput("late_top_count",   32'(cntQ),        32'(15));
                checkOutput("late_top_toggled", 32'(bus.toggled), 32'(1));
            end
            if (i == 17) checkOutput("late_reverse_count", 32'(cntQ), 32'(14));
        end

        $display("[TB] reset in the middle of a release debounce");
        bus.mode = 1'b0;
        doReset(2);
        applyStimulus(1'b1, 1'b0, 8);
        checkOutput("mid_pre_upDown", 32'(bus.upDown), 32'(0));
        applyStimulus(1'b0, 1'b0, 3);
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_upDown",    32'(bus.upDown),    32'(1));
        checkOutput("arst_btn_level", 32'(bus.btn_level), 32'(0));
        checkOutput("arst_toggled",   32'(bus.toggled),   32'(0));
        bus.button = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clock);
            if (e == 5) checkOutput("rearm_edge5_upDown", 32'(bus.upDown), 32'(1));
            if (e == 6) checkOutput("rearm_edge6_upDown", 32'(bus.upDown), 32'(0));
        end
        applyStimulus(1'b0, 1'b0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/up_down_control.md
UP_DOWN_CONTROL -- requirements
Module: up_down_control

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive clock cycles a synchronized button level must differ from the debounced level before it is accepted (legal range 2..255).
REQ-002 Parameter WIDTH, default 4: width of the fed-back count bus; COUNT_MAX = 2**WIDTH-1.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 button  input  1  raw asynchronous push-button, high = pressed.
REQ-006 mode  input  1  0 = manual (button toggles direction), 1 = ping-pong (auto-reverse at ends, button still toggles).
REQ-007 count  input  WIDTH  registered count fed back from the downstream up/down counter.
REQ-008 upDown  output  1  direction to the counter: 1 = up, 0 = down; registered.
REQ-009 toggled  output  1  one-cycle registered pulse, high in the cycle following every upDown change.
REQ-010 btn_level  output  1  debounced button level; registered.

Function
REQ-011 button SHALL pass through a two-flop synchronizer before any other use.
REQ-012 Debounce counter SHALL increment each cycle the synchronized level differs from btn_level and clear to 0 in any cycle they match.
REQ-013 btn_level SHALL take the synchronized level at the edge the debounce counter would reach DEBOUNCE_CYCLES; counter clears at that edge.
REQ-014 A press event SHALL be the 0->1 transition of btn_level; release (1->0) SHALL produce no event.
REQ-015 Direction FSM SHALL have two states, DIR_UP and DIR_DOWN; upDown = 1 exactly in DIR_UP.
REQ-016 In both modes, a press event SHALL flip the FSM state at the same edge btn_level rises.
REQ-017 Latency: button held high from before edge 1 SHALL give btn_level=1 and upDown flipped after edge 2+DEBOUNCE_CYCLES (edge 6 at default).
REQ-018 Ping-pong, DIR_UP: count == COUNT_MAX-1 SHALL flip to DIR_DOWN at that edge, so the counter reaches COUNT_MAX then reverses without wrapping.
REQ-019 Ping-pong, DIR_DOWN: count == 1 SHALL flip to DIR_UP at that edge, so the counter reaches 0 then reverses.
REQ-020 No other count value SHALL cause a flip; entering ping-pong with count at COUNT_MAX while up SHALL let the counter wrap to 0 and continue up.
REQ-021 Press event and terminal condition in the same cycle SHALL produce exactly one flip and one toggled pulse.
REQ-022 mode SHALL be sampled every cycle with no internal latch; a change takes effect on the next edge.
REQ-023 Glitches shorter than DEBOUNCE_CYCLES cycles after synchronization SHALL never change btn_level or upDown.

Reset
REQ-024 While reset is low: upDown=1 (DIR_UP), toggled=0, btn_level=0, synchronizer flops=0, debounce counter=0.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; button held through deassertion SHALL be re-debounced from zero and then produce a press event.
REQ-026 Reset deassertion SHALL be synchronous to clock at the system level; the block does no internal reset synchronization.

Structure
REQ-027 Shared package up_down_pkg SHALL hold dir_state_t {DIR_UP, DIR_DOWN} and DEFAULT_DEBOUNCE_CYCLES=4.
REQ-028 Synchronizer, debounce counter and rising-edge detector SHALL form one sub-module, button_debounce (outputs level and press pulse); FSM and ping-pong logic stay in up_down_control.
REQ-029 No combinational path SHALL exist from any input to any output.

Verification
REQ-030 Reset: hold reset low 3 cycles, button=1 -> upDown=1, toggled=0, btn_level=0 throughout; after release, upDown flips at edge 2+DEBOUNCE_CYCLES.
REQ-031 Manual debounce: mode=0, button pulses of 1,2,3 cycles -> no change; 10-cycle press -> upDown 1->0 exactly once, toggled high one cycle; release and second press -> upDown back to 1.
REQ-032 Ping-pong closed loop with a 4-bit up/down counter, mode=1 from reset -> count sequence 0,1,...,15,14,...,0,1 with no wrap; toggled pulses after count 15 and after count 0.
REQ-033 Simultaneous: mode=1, time press so btn_level rises the edge count==14 while up -> single flip to down, one toggled pulse, count tops out at 15.
REQ-034 Late mode entry: mode=0, count=15, upDown=1, then set mode=1 -> counter wraps to 0, continues up, reverses at 15 on next pass.
REQ-035 Reset mid-operation: assert reset while upDown=0 and debounce counter nonzero -> upDown=1 immediately (asynchronously), btn_level=0, no toggled pulse.
